cordic_rotator: RTL and testbench

- Iterative rotation-mode CORDIC engine that sits directly upstream of the CORDIC output/bus stage.
- Takes an angle and iteratively computes cosine on X and sine on Y.
- Raises a one-cycle `done` when X/Y are final; the downstream stage captures X on `done`.
- All data is signed Q3.29 fixed point: 1.0 = 0x2000_0000, pi = 0x6487_ED51.

---
 rtl/cordic_rotator.sv | 181 ++++++++++++++++++
 tb/tb_cordic_rotator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC, signed Q3.29.
// Folds the angle into [-pi/2, pi/2], pre-scales by the CORDIC gain and
// runs ITER shift-add micro-rotations. X ends as cos(angle) and Y as sin(angle).
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset; aborts any computation
//   start    - request pulse, accepted in IDLE and DONE only
//   angle_in - signed angle in radians, Q3.29 (saturated to [-pi, pi])
//   X, Y     - registered cosine / sine; update only when entering DONE
//   done     - one-cycle pulse while X/Y hold a fresh result
//   busy     - high during PREP and ROT
module cordic_rotator #(
  parameter int WIDTH = 32,
  parameter int ITER  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] angle_in,
  output logic signed [WIDTH-1:0] X,
  output logic signed [WIDTH-1:0] Y,
  output logic                    done,
  output logic                    busy
);

  localparam logic signed [WIDTH-1:0] PI          = WIDTH'(32'sh6487_ED51);
  localparam logic signed [WIDTH-1:0] NEG_PI      = -PI;
  localparam logic signed [WIDTH-1:0] HALF_PI     = WIDTH'(32'sh3243_F6A9);
  localparam logic signed [WIDTH-1:0] NEG_HALF_PI = -HALF_PI;
  localparam logic signed [WIDTH-1:0] KGAIN       = WIDTH'(32'sh136E_9DB5);
  localparam logic signed [WIDTH-1:0] NEG_KGAIN   = -KGAIN;
  localparam logic [4:0]              LAST        = 5'(ITER - 1);

  typedef enum logic [1:0] {IDLE, PREP, ROT, DONE} state_t;

  state_t                  state, state_nx;
  logic signed [WIDTH-1:0] x, y, z;
  logic [4:0]              i;

  logic signed [WIDTH-1:0] a_sat, z_fold, x_init;
  logic signed [WIDTH-1:0] x_rot, y_rot, z_rot;
  logic signed [WIDTH-1:0] xs, ys, at;

  // round(atan(2^-idx) * 2^29)
  function automatic logic signed [WIDTH-1:0] atan_entry(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_entry = WIDTH'(32'sh1921_FB54);
      5'd1:    atan_entry = WIDTH'(32'sh0ED6_3383);
      5'd2:    atan_entry = WIDTH'(32'sh07D6_DD7E);
      5'd3:    atan_entry = WIDTH'(32'sh03FA_B753);
      5'd4:    atan_entry = WIDTH'(32'sh01FF_55BB);
      5'd5:    atan_entry = WIDTH'(32'sh00FF_EAAE);
      5'd6:    atan_entry = WIDTH'(32'sh007F_FD55);
      5'd7:    atan_entry = WIDTH'(32'sh003F_FFAB);
      5'd8:    atan_entry = WIDTH'(32'sh001F_FFF5);
      5'd9:    atan_entry = WIDTH'(32'sh000F_FFFF);
      5'd10:   atan_entry = WIDTH'(32'sh0008_0000);
      5'd11:   atan_entry = WIDTH'(32'sh0004_0000);
      5'd12:   atan_entry = WIDTH'(32'sh0002_0000);
      5'd13:   atan_entry = WIDTH'(32'sh0001_0000);
      5'd14:   atan_entry = WIDTH'(32'sh0000_8000);
      5'd15:   atan_entry = WIDTH'(32'sh0000_4000);
      5'd16:   atan_entry = WIDTH'(32'sh0000_2000);
      5'd17:   atan_entry = WIDTH'(32'sh0000_1000);
      5'd18:   atan_entry = WIDTH'(32'sh0000_0800);
      5'd19:   atan_entry = WIDTH'(32'sh0000_0400);
      5'd20:   atan_entry = WIDTH'(32'sh0000_0200);
      5'd21:   atan_entry = WIDTH'(32'sh0000_0100);
      5'd22:   atan_entry = WIDTH'(32'sh0000_0080);
      5'd23:   atan_entry = WIDTH'(32'sh0000_0040);
      5'd24:   atan_entry = WIDTH'(32'sh0000_0020);
      5'd25:   atan_entry = WIDTH'(32'sh0000_0010);
      5'd26:   atan_entry = WIDTH'(32'sh0000_0008);
      5'd27:   atan_entry = WIDTH'(32'sh0000_0004);
      5'd28:   atan_entry = WIDTH'(32'sh0000_0002);
      5'd29:   atan_entry = WIDTH'(32'sh0000_0001);
      default: atan_entry = '0;
    endcase
  endfunction

  // Saturate, then fold |a| > pi/2 by rotating half a turn: starting from
  // (-K, 0) and rotating by a -/+ pi lands on (cos a, sin a).
  always_comb begin
    a_sat  = z;
    z_fold = '0;
    x_init = KGAIN;
    if (z > PI)
      a_sat = PI;
    else if (z < NEG_PI)
      a_sat = NEG_PI;
    if (a_sat > HALF_PI) begin
      z_fold = a_sat - PI;
      x_init = NEG_KGAIN;
    end else if (a_sat < NEG_HALF_PI) begin
      z_fold = a_sat + PI;
      x_init = NEG_KGAIN;
    end else begin
      z_fold = a_sat;
    end
  end

  // One micro-rotation, direction chosen to drive z toward zero.
  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    at = atan_entry(i);
    if (!z[WIDTH-1]) begin
      x_rot = x - ys;
      y_rot = y + xs;
      z_rot = z - at;
    end else begin
      x_rot = x + ys;
      y_rot = y - xs;
      z_rot = z + at;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = PREP;
      PREP: begin
        busy     = 1'b1;
        state_nx = ROT;
      end
      ROT: begin
        busy = 1'b1;
        if (i == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? PREP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // z doubles as the latched angle until PREP replaces it with the folded one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      X <= '0;
      Y <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) z <= angle_in;
        PREP: begin
          x <= x_init;
          y <= '0;
          z <= z_fold;
          i <= '0;
        end
        ROT: begin
          x <= x_rot;
          y <= y_rot;
          z <= z_rot;
          i <= i + 5'd1;
          if (i == LAST) begin
            X <= x_rot;
            Y <= y_rot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: directed and swept checks of cordic_rotator.
// Expected results are Q3.29 constants (or a real cos/sin model for the
// sweep) compared within +/-256 LSB.
module tb_cordic_rotator;

  localparam int ITER = 24;
  localparam int TOL  = 256;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [31:0] angle_in;
  logic signed [31:0] X;
  logic signed [31:0] Y;
  logic               done;
  logic               busy;

  int checks = 0;
  int errors = 0;

  cordic_rotator #(.WIDTH(32), .ITER(ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .angle_in (angle_in),
    .X        (X),
    .Y        (Y),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    checks++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  // Presents start for one edge; angle_in is then scrambled so a late
  // change on the bus would corrupt the result if it were not latched.
  task automatic launch(input logic signed [31:0] ang);
    angle_in = ang;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    angle_in = ~ang;
  endtask

  // Called #1 after the sampling edge. Returns edges until done, number of
  // busy samples, and whether X/Y held still before done.
  task automatic wait_done(input bit poke, output int lat, output int bcnt,
                           output bit stable);
    logic signed [31:0] x0, y0;
    x0     = X;
    y0     = Y;
    lat    = 0;
    bcnt   = busy ? 1 : 0;
    stable = 1'b1;
    while (!done && lat < 100) begin
      if (poke && lat == 5) begin
        start    = 1'b1;
        angle_in = 32'sh1000_0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
      if (!done && (X != x0 || Y != y0)) stable = 1'b0;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string              name;
    logic signed [31:0] ang;
    logic signed [31:0] ex;
    logic signed [31:0] ey;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, bcnt, lat2;
    bit stable;
    bit seen;
    logic signed [31:0] ang;
    real ar;

    vecs[0] = '{"zero",      32'sh0000_0000, 32'sh2000_0000, 32'sh0000_0000};
    vecs[1] = '{"pi6",       32'sh10C1_5238, 32'sh1BB6_7AE8, 32'sh1000_0000};
    vecs[2] = '{"3pi4",      32'sh4B65_F1FC, 32'shE95F_619A, 32'sh16A0_9E66};
    vecs[3] = '{"m3pi4",     32'shB49A_0E04, 32'shE95F_619A, 32'shE95F_619A};
    vecs[4] = '{"pi",        32'sh6487_ED51, 32'shE000_0000, 32'sh0000_0000};
    vecs[5] = '{"sat_pos",   32'sh7FFF_FFFF, 32'shE000_0000, 32'sh0000_0000};
    vecs[6] = '{"sat_neg",   32'sh8000_0000, 32'shE000_0000, 32'sh0000_0000};
    vecs[7] = '{"half_pi",   32'sh3243_F6A9, 32'sh0000_0000, 32'sh2000_0000};
    vecs[8] = '{"m_half_pi", 32'shCDBC_0957, 32'sh0000_0000, 32'shE000_0000};

    rst      = 1'b0;
    start    = 1'b0;
    angle_in = '0;

    // Asynchronous reset asserted mid-cycle.
    #3 rst = 1'b1;
    #1;
    check("rst_X", X, 0);
    check("rst_Y", Y, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Directed vectors: value, latency (done in cycle 26 counting the start
    // cycle as 0, i.e. ITER+1 edges after sampling), busy width, hold, pulse width.
    foreach (vecs[k]) begin
      @(negedge clk);
      launch(vecs[k].ang);
      wait_done(1'b0, lat, bcnt, stable);
      check($sformatf("%s_lat", vecs[k].name), lat, ITER + 1);
      check($sformatf("%s_busy", vecs[k].name), bcnt, ITER + 1);
      check($sformatf("%s_hold", vecs[k].name), stable, 1);
      check($sformatf("%s_X", vecs[k].name), X, vecs[k].ex, TOL);
      check($sformatf("%s_Y", vecs[k].name), Y, vecs[k].ey, TOL);
      @(posedge clk);
      #1;
      check($sformatf("%s_done_w", vecs[k].name), done, 0);
    end

    // Extra start during busy must be ignored.
    @(negedge clk);
    launch(32'sh10C1_5238);
    wait_done(1'b1, lat, bcnt, stable);
    check("poke_lat", lat, ITER + 1);
    check("poke_hold", stable, 1);
    check("poke_X", X, 32'sh1BB6_7AE8, TOL);
    check("poke_Y", Y, 32'sh1000_0000, TOL);
    @(posedge clk);
    #1;
    check("poke_idle", busy, 0);

    // Back-to-back: start in the DONE cycle, next done 26 edges later.
    @(negedge clk);
    launch(32'sh10C1_5238);
    wait_done(1'b0, lat, bcnt, stable);
    check("b2b1_X", X, 32'sh1BB6_7AE8, TOL);
    check("b2b1_done", done, 1);
    launch(32'sh4B65_F1FC);
    check("b2b_busy", busy, 1);
    wait_done(1'b0, lat2, bcnt, stable);
    check("b2b_gap", lat2 + 1, ITER + 2);
    check("b2b2_X", X, 32'shE95F_619A, TOL);
    check("b2b2_Y", Y, 32'sh16A0_9E66, TOL);

    // Reset in the middle of ROT.
    @(negedge clk);
    launch(32'sh10C1_5238);
    for (int n = 0; n < 11; n++) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_X", X, 0);
    check("mid_rst_Y", Y, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("mid_rst_quiet", seen, 0);

    @(negedge clk);
    launch(32'sh10C1_5238);
    wait_done(1'b0, lat, bcnt, stable);
    check("after_rst_lat", lat, ITER + 1);
    check("after_rst_X", X, 32'sh1BB6_7AE8, TOL);
    check("after_rst_Y", Y, 32'sh1000_0000, TOL);

    // Sweep against a real-valued model.
    for (int n = 0; n < 1000; n++) begin
      ang = 32'($urandom_range(32'hC90F_DAA2, 0)) - 32'sh6487_ED51;
      ar  = real'(ang) / 536870912.0;
      @(negedge clk);
      launch(ang);
      wait_done(1'b0, lat, bcnt, stable);
      check($sformatf("sweep%0d_X", n), X, longint'($cos(ar) * 536870912.0), TOL);
      check($sformatf("sweep%0d_Y", n), Y, longint'($sin(ar) * 536870912.0), TOL);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
